// File: rtl/pixel_serializer.sv
// rtl/pixel_serializer.sv - multi-plane pixel serializer with word FIFO and sticky underflow
//
// Buffers PLANES*WIDTH-bit display words in a DEPTH-entry FIFO and shifts
// them out MSB-first, one pixel per plane in parallel, holding each pixel
// for mult+1 enabled cycles.
//
// Ports:
//   clk         pixel clock
//   reset       asynchronous active-high reset
//   line_start  synchronous flush/restart for a new scanline
//   wr_valid    wr_data is valid
//   wr_ready    FIFO can accept (!full && !line_start), combinational
//   wr_data     plane p at [p*WIDTH +: WIDTH]
//   enable      pixel-advance qualifier; all state holds when low
//   mult        pixel repeat count less one
//   q           current pixel, q[p] from plane p
//   q_valid     q carries real pixel data
//   underflow   sticky: shifter ran dry mid-line
module pixel_serializer #(
    parameter int WIDTH  = 16,
    parameter int PLANES = 2,
    parameter int DEPTH  = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      line_start,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [PLANES*WIDTH-1:0]   wr_data,
    input  logic                      enable,
    input  logic [3:0]                mult,
    output logic [PLANES-1:0]         q,
    output logic                      q_valid,
    output logic                      underflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = $clog2(WIDTH);

    logic [PLANES*WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [CW-1:0]           count;

    logic [PLANES*WIDTH-1:0] shreg;
    logic [BW-1:0]           bit_cnt;
    logic [3:0]              rep_cnt;
    logic                    loaded;
    logic                    active;

    logic                    full;
    logic                    empty;
    logic                    do_write;
    logic                    do_pop;
    logic                    advance;
    logic                    bits_remain;
    logic [PLANES*WIDTH-1:0] shifted;
    logic [PLANES-1:0]       next_bits;
    logic [PLANES-1:0]       head_msbs;
    logic [PLANES*WIDTH-1:0] head_word;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        full        = (count == CW'(DEPTH));
        empty       = (count == '0);
        wr_ready    = !full && !line_start;
        do_write    = wr_valid && wr_ready;
        advance     = enable && (!loaded || rep_cnt == mult);
        // An unloaded shifter has no bits left regardless of bit_cnt.
        bits_remain = loaded && (bit_cnt != BW'(WIDTH - 1));
        do_pop      = advance && !bits_remain && !empty;
        head_word   = mem[rd_ptr];
    end

    // q is taken from the bit just below the current MSB on a shift, so the
    // shift register always holds the pixel currently on q at its top.
    always_comb begin
        shifted   = '0;
        next_bits = '0;
        head_msbs = '0;
        for (int p = 0; p < PLANES; p++) begin
            shifted[p*WIDTH +: WIDTH] = {shreg[p*WIDTH +: WIDTH-1], 1'b0};
            next_bits[p]              = shreg[p*WIDTH + WIDTH - 2];
            head_msbs[p]              = head_word[p*WIDTH + WIDTH - 1];
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            shreg     <= '0;
            bit_cnt   <= '0;
            rep_cnt   <= '0;
            loaded    <= 1'b0;
            active    <= 1'b0;
            q         <= '0;
            q_valid   <= 1'b0;
            underflow <= 1'b0;
        end else if (line_start) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            shreg     <= '0;
            bit_cnt   <= '0;
            rep_cnt   <= '0;
            loaded    <= 1'b0;
            active    <= 1'b0;
            q         <= '0;
            q_valid   <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_write && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_write && do_pop) begin
                count <= count - CW'(1);
            end

            if (enable) begin
                if (!advance) begin
                    // Wraps through 15 when mult drops below the running count.
                    rep_cnt <= rep_cnt + 4'd1;
                end else begin
                    rep_cnt <= '0;
                    if (bits_remain) begin
                        shreg   <= shifted;
                        q       <= next_bits;
                        bit_cnt <= bit_cnt + BW'(1);
                    end else if (!empty) begin
                        shreg   <= head_word;
                        q       <= head_msbs;
                        bit_cnt <= '0;
                        loaded  <= 1'b1;
                        q_valid <= 1'b1;
                        active  <= 1'b1;
                    end else begin
                        loaded  <= 1'b0;
                        q       <= '0;
                        q_valid <= 1'b0;
                        if (active) begin
                            underflow <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: doc/pixel_serializer.md
# pixel_serializer

Parametrised multi-plane pixel serializer for the display path. It accepts display words of `WIDTH` pixels per plane through a valid/ready handshake and buffers them in a `DEPTH`-entry FIFO. It shifts them out MSB-first, one pixel per plane in parallel, and holds each pixel for `mult+1` enabled pixel-clock cycles. Word boundaries are seamless. An explicit bit counter replaces the sentinel-bit scheme. A sticky underflow flag reports when the source falls behind. It sits between the framebuffer fetch logic and the video output/palette stage.

## Interface
- `WIDTH`, 16, pixels per word per plane (≥2).
- `PLANES`, 2, parallel bit-planes (≥1).
- `DEPTH`, 2, FIFO words ahead of the shift register (≥1).
- `clk`  in  1  pixel clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `line_start`  in  1  synchronous flush/restart for a new scanline.
- `wr_valid`  in  1  `wr_data` is valid.
- `wr_ready`  out  1  FIFO can accept; combinational: `!full && !line_start`.
- `wr_data`  in  PLANES*WIDTH  plane p at `[p*WIDTH +: WIDTH]`.
- `enable`  in  1  pixel-advance qualifier; the block holds all state when low.
- `mult`  in  4  pixel repeat count less one (0..15), sampled each enabled cycle.
- `q`  out  PLANES  current pixel; `q[p]` comes from plane p; registered.
- `q_valid`  out  1  `q` carries real pixel data; registered.
- `underflow`  out  1  sticky: the shifter ran dry mid-line.

## Operation
- Reset value of every output register: `q`=0, `q_valid`=0, `underflow`=0. FIFO empty, shifter empty, `active`=0, counters 0.
- **Write:** a word is accepted when `wr_valid && wr_ready`. A write in the same cycle as a pop to the shifter is allowed. A full FIFO refuses writes even if it pops that cycle.
- **Shifter state:** PLANES shift registers of WIDTH bits, a bit counter (0..WIDTH-1), a repeat counter (0..15) and a `loaded` flag.
- **Advance event:** an `enable` cycle in which `!loaded` or repeat counter == `mult`. On any other enable cycle the repeat counter increments.
- **On an advance event:**
  - Bits remain (bit counter < WIDTH-1): shift all planes left, `q` ← next MSBs, bit counter +1, repeat counter ← 0.
  - Else, FIFO non-empty: pop, load all planes, `q` ← MSBs, bit counter ← 0, repeat counter ← 0, `loaded`=1, `q_valid`=1, `active`=1.
  - Else (FIFO empty): `loaded`=0, `q`=0, `q_valid`=0. If `active`, set `underflow`.
- **`line_start` (priority over everything except `reset`):** flush the FIFO, clear the shifter and counters, `loaded`=0, `active`=0, `q`=0, `q_valid`=0, `underflow`=0. Any write that cycle is discarded.
- `underflow` stays set until `line_start` or `reset`.
- A change of `mult` mid-pixel takes effect at the next compare. If the repeat counter already exceeds the new `mult`, it counts up to 15, wraps to 0, and continues until it equals `mult`.
- Pixel order within a word: bit WIDTH-1 first, bit 0 last.

## Timing
- **Write-to-pixel latency:** from an idle, empty block with `enable` held high, a word written at cycle N appears on `q`/`q_valid` after the edge of cycle N+1. The FIFO is written at N; the shifter pops at N+1.
- Each pixel stays on `q` for exactly `mult+1` enable-high cycles.
- One word occupies WIDTH·(`mult`+1) enable cycles.
- **Word boundary:** the next word's MSB follows the previous LSB with no gap or extra cycle, provided the FIFO is non-empty at that advance event.
- **`enable` low:** `q`, `q_valid`, counters and FIFO contents are frozen. Writes are still accepted.
- `underflow` rises on the same edge that `q_valid` falls.
- An asynchronous `reset` asserted mid-word clears outputs immediately. The block has no memory of the aborted word.

## Test plan
- **Reset:** assert `reset` mid-stream → `q`=0, `q_valid`=0, `underflow`=0 and `wr_ready`=1 immediately, before any clock edge.
- **Basic serialization:** PLANES=2, `mult`=0, one word plane0=16'h8001 and plane1=16'hFFFF, `enable` high → `q` = 2'b11, then 2'b10 ×14, then 2'b11. Run = 16 cycles, `q_valid`=1 throughout, then `q_valid`=0 and `underflow`=1.
- **Repeat:** `mult`=2, plane0=16'hAAAA → each pixel is held 3 cycles, 48 cycles total; `q[0]` pattern 111000 repeated.
- **Seamless boundary and backpressure:** DEPTH=2, `enable` low, write 3 words → the first two are accepted, then `wr_ready`=0. Raise `enable` → 48 consecutive `q_valid` cycles with no bubble at word boundaries, and `underflow`=0 while writes keep pace.
- **Enable gaps:** toggle `enable` 1/0 during a word with `mult`=1 → each pixel spans 2 enable-high cycles, and `q` is unchanged on enable-low cycles.
- **`line_start`:** assert with a word in flight and `underflow`=1 → next cycle FIFO empty, `q_valid`=0, `underflow`=0. A simultaneous write is dropped and `wr_ready`=0 that cycle.
